// File: rtl/cart_bus_arbiter.sv
// Cartridge bus arbiter: the Game Boy core (port 0) and the debug engine (port 1)
// share one bus; each access runs setup -> strobe -> hold -> done with registered pins.
module cart_bus_arbiter #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned MAX_STREAK    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [15:0] core_addr,
    input  logic [7:0]  core_wdata,
    output logic        core_ack,
    output logic [7:0]  core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_ack,
    output logic [7:0]  dbg_rdata,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    input  logic [7:0]  bus_din,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        bus_cs,
    output logic        busy
);
    // Out-of-range phase lengths are clamped to 1..15 so the 4-bit counters never wrap.
    localparam int unsigned SETUP_EFF  = (SETUP_CYCLES  == 0) ? 1 : ((SETUP_CYCLES  > 15) ? 15 : SETUP_CYCLES);
    localparam int unsigned STROBE_EFF = (STROBE_CYCLES == 0) ? 1 : ((STROBE_CYCLES > 15) ? 15 : STROBE_CYCLES);
    localparam int unsigned HOLD_EFF   = (HOLD_CYCLES   == 0) ? 1 : ((HOLD_CYCLES   > 15) ? 15 : HOLD_CYCLES);
    localparam int unsigned STREAK_EFF = (MAX_STREAK    == 0) ? 1 : ((MAX_STREAK    > 15) ? 15 : MAX_STREAK);

    localparam logic [3:0] SETUP_LD   = 4'(SETUP_EFF - 1);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_EFF - 1);
    localparam logic [3:0] HOLD_LD    = 4'(HOLD_EFF - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STREAK_EFF);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_e;

    state_e      state_q;
    logic [3:0]  phase_q;
    logic [3:0]  streak_q;
    logic        grant_dbg_q;
    logic        we_q;
    logic [15:0] bus_a_q;
    logic [7:0]  bus_dout_q;
    logic        bus_oe_q;
    logic        bus_cs_q;
    logic        bus_rd_q;
    logic        bus_wr_q;
    logic        core_ack_q;
    logic        dbg_ack_q;
    logic [7:0]  core_rdata_q;
    logic [7:0]  dbg_rdata_q;

    logic        grant_any_d;
    logic        grant_dbg_d;
    logic        sel_we_d;
    logic [15:0] sel_addr_d;
    logic [7:0]  sel_wdata_d;

    // Core has priority unless it has already won MAX_STREAK times while debug waited.
    always_comb begin
        grant_any_d = core_req | dbg_req;
        grant_dbg_d = dbg_req & (~core_req | (streak_q == STREAK_MAX));
        sel_we_d    = grant_dbg_d ? dbg_we    : core_we;
        sel_addr_d  = grant_dbg_d ? dbg_addr  : core_addr;
        sel_wdata_d = grant_dbg_d ? dbg_wdata : core_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: strobes, cs and oe are flops on the async reset, so they fall the instant rst_n drops.
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            streak_q     <= '0;
            grant_dbg_q  <= 1'b0;
            we_q         <= 1'b0;
            bus_a_q      <= '0;
            bus_dout_q   <= '0;
            bus_oe_q     <= 1'b0;
            bus_cs_q     <= 1'b0;
            bus_rd_q     <= 1'b0;
            bus_wr_q     <= 1'b0;
            core_ack_q   <= 1'b0;
            dbg_ack_q    <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            // NOTE: acks default low every clock, so setting one can only ever produce a single-cycle pulse.
            core_ack_q <= 1'b0;
            dbg_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!dbg_req) streak_q <= '0;
                    if (grant_any_d) begin
                        state_q     <= SETUP;
                        phase_q     <= SETUP_LD;
                        grant_dbg_q <= grant_dbg_d;
                        we_q        <= sel_we_d;
                        bus_a_q     <= sel_addr_d;
                        bus_dout_q  <= sel_wdata_d;
                        bus_cs_q    <= (sel_addr_d[15:13] == 3'b101);
                        bus_oe_q    <= sel_we_d;
                        if (grant_dbg_d) begin
                            streak_q <= '0;
                        end else if (dbg_req && streak_q != STREAK_MAX) begin
                            streak_q <= streak_q + 4'd1;
                        end
                    end
                end
                SETUP: begin
                    if (phase_q == 4'd0) begin
                        state_q  <= STROBE;
                        phase_q  <= STROBE_LD;
                        bus_rd_q <= ~we_q;
                        bus_wr_q <= we_q;
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                STROBE: begin
                    if (phase_q == 4'd0) begin
                        state_q  <= HOLD;
                        phase_q  <= HOLD_LD;
                        bus_rd_q <= 1'b0;
                        bus_wr_q <= 1'b0;
                        if (!we_q) begin
                            if (grant_dbg_q) dbg_rdata_q  <= bus_din;
                            else             core_rdata_q <= bus_din;
                        end
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (phase_q == 4'd0) begin
                        state_q    <= DONE;
                        bus_cs_q   <= 1'b0;
                        bus_oe_q   <= 1'b0;
                        core_ack_q <= ~grant_dbg_q;
                        dbg_ack_q  <= grant_dbg_q;
                    end else begin
                        phase_q <= phase_q - 4'd1;
                    end
                end
                DONE: begin
                    // Gap cycle: lets the requester drop or renew before IDLE samples again.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_ack   = core_ack_q;
    assign dbg_ack    = dbg_ack_q;
    assign core_rdata = core_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign bus_a      = bus_a_q;
    assign bus_dout   = bus_dout_q;
    assign bus_oe     = bus_oe_q;
    assign bus_rd     = bus_rd_q;
    assign bus_wr     = bus_wr_q;
    assign bus_cs     = bus_cs_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/cart_bus_arbiter.md
Name: cart_bus_arbiter

Overview:
- Shares the external cartridge bus (address, data, rd/wr/cs strobes) between two requesters: the Game Boy core (port 0) and the debug/UART memory-access engine (port 1).
- Sequences each access as setup -> strobe -> hold with parameterised cycle counts.
- Returns read data and a one-cycle ack to whichever requester was granted.
- Sits between the core and the top-level cartridge pins. The top level applies pin polarity inversion and tri-state, driven from bus_oe.

Parameters:
- SETUP_CYCLES, 1, cycles address/cs are stable before the strobe (range 1..15; 0 treated as 1).
- STROBE_CYCLES, 2, cycles rd or wr is asserted (range 1..15; 0 treated as 1).
- HOLD_CYCLES, 1, cycles address/data are held after the strobe drops (range 1..15; 0 treated as 1).
- MAX_STREAK, 4, consecutive core grants allowed while debug is pending before debug is forced (range 1..15).

Ports:
- clk  in  1  arbiter clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; level, held until core_ack.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  16  core address.
- core_wdata  in  8  core write data.
- core_ack  out  1  one-cycle completion pulse.
- core_rdata  out  8  read data; valid with core_ack, held until the next core read completes.
- dbg_req  in  1  debug request; same protocol as core_req.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  16  debug address.
- dbg_wdata  in  8  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  8  read data; same rules as core_rdata.
- bus_a  out  16  cartridge address.
- bus_dout  out  8  cartridge write data.
- bus_oe  out  1  drive bus_dout onto the data pins.
- bus_din  in  8  cartridge read data.
- bus_rd  out  1  read strobe, active-high.
- bus_wr  out  1  write strobe, active-high.
- bus_cs  out  1  external-RAM chip select, active-high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): all outputs 0, including bus_a and both rdata. FSM goes to IDLE and the streak counter clears. An access in progress is aborted immediately: strobes drop combinationally with reset and no ack is ever issued for it.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: each cycle, sample the requests and pick a winner.
  - Core only pending: core wins.
  - Debug only pending: debug wins.
  - Both pending: core wins, unless streak == MAX_STREAK, in which case debug wins.
- On a grant: latch grant id, we, addr and wdata; load the phase counter; go to SETUP.
- Inputs are sampled only in IDLE. Changes on req/addr/data during an access are ignored.
- SETUP (SETUP_CYCLES cycles): bus_a = latched addr; bus_cs = (addr[15:13] == 3'b101); bus_oe = we; bus_dout = wdata.
- STROBE (STROBE_CYCLES cycles):
  - bus_rd = !we and bus_wr = we. Both strobes are register outputs and are never high together.
  - Read: on the last STROBE cycle edge, capture bus_din into the granted requester's rdata register.
- HOLD (HOLD_CYCLES cycles): strobes low; bus_a, bus_cs, bus_oe and bus_dout unchanged.
- DONE (1 cycle):
  - ack = 1 for the granted requester only.
  - bus_cs = 0 and bus_oe = 0. bus_a retains its last value.
  - No grant is taken in DONE, which gives the requester one cycle to drop or renew its request.
  - Next state is IDLE.
- Latency: request accepted at edge N -> ack high during cycle N + SETUP + STROBE + HOLD + 1. With defaults: ack in cycle N+5; next grant earliest at edge N+6.
- Streak counter:
  - Increments when core is granted while dbg_req is high (saturates at MAX_STREAK).
  - Clears when debug is granted, or when IDLE samples dbg_req low.
- Phase counters are 4-bit down-counters.

Test Plan:
- Core read: core_req=1, addr=0x0150, bus_din=0x3C, we=0 -> bus_rd high in cycles 2-3 after accept, bus_cs=0, core_ack in cycle 5, core_rdata=0x3C, dbg_ack stays 0.
- Debug write to external RAM: dbg_req=1, addr=0xA010, wdata=0x5A -> bus_cs=1 and bus_oe=1 over SETUP..HOLD, bus_dout=0x5A, bus_wr high 2 cycles, dbg_ack once, bus_rd never high.
- Contention/starvation: core_req and dbg_req held high continuously -> grant order core x4, debug, core x4, debug; exactly one ack per access.
- Simultaneous first request: both asserted in the same IDLE cycle with streak=0 -> core granted first, debug second, 6 cycles apart.
- Reset mid-strobe: drop rst_n during STROBE of a write -> bus_wr, bus_oe, bus_cs go 0 immediately; no ack. After release, a pending req is served normally.
- Parameter sweep: SETUP=3, STROBE=5, HOLD=2 -> ack exactly 11 cycles after accept; strobe width 5 cycles measured.
